// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions: response codes, the manager state encoding
// and default bus widths.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_WIDTH   = 4;
  localparam int unsigned AXI_DATA_WIDTH   = 32;
  localparam logic [2:0]  AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    MGR_IDLE    = 3'd0,
    MGR_WR_REQ  = 3'd1,
    MGR_WR_RESP = 3'd2,
    MGR_RD_REQ  = 3'd3,
    MGR_RD_RESP = 3'd4,
    MGR_DONE    = 3'd5
  } axi_mgr_state_t;

endpackage

// File: rtl/axi_lite_manager.sv
// -----------------------------------------------------------------------------
// axi_lite_manager
// AXI4-Lite initiator that turns one command at a time into a single AXI-Lite
// write (AW+W+B) or read (AR+R) and returns the result on a held response port.
//
// Ports:
//   axi_aclk_in / axi_areset_in   clock, synchronous active-high reset
//   cmd_*                         command request (valid/ready handshake)
//   rsp_*                         response, held until rsp_ready_in
//   axi_aw* / axi_w* / axi_b*     AXI-Lite write address, data, response
//   axi_ar* / axi_r*              AXI-Lite read address, data
//
// All AXI valid/ready outputs are registered, so no VALID ever depends
// combinationally on a READY input.
// -----------------------------------------------------------------------------
module axi_lite_manager
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
  parameter logic [2:0]  PROT       = AXI_PROT_DEFAULT
) (
  input  logic                    axi_aclk_in,
  input  logic                    axi_areset_in,
  // command port
  input  logic                    cmd_valid_in,
  output logic                    cmd_ready_out,
  input  logic                    cmd_write_in,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_in,
  // response port
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic                    rsp_write_out,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic [1:0]              rsp_resp_out,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]   axi_awaddr_out,
  output logic [2:0]              axi_awprot_out,
  output logic                    axi_awvalid_out,
  input  logic                    axi_awready_in,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   axi_wdata_out,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb_out,
  output logic                    axi_wvalid_out,
  input  logic                    axi_wready_in,
  // AXI write response
  input  logic [1:0]              axi_bresp_in,
  input  logic                    axi_bvalid_in,
  output logic                    axi_bready_out,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]   axi_araddr_out,
  output logic [2:0]              axi_arprot_out,
  output logic                    axi_arvalid_out,
  input  logic                    axi_arready_in,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]   axi_rdata_in,
  input  logic [1:0]              axi_rresp_in,
  input  logic                    axi_rvalid_in,
  output logic                    axi_rready_out
);

  axi_mgr_state_t          state_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    rsp_valid_q;
  logic                    rsp_write_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  axi_resp_t               rsp_resp_q;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q & axi_awready_in;
  assign w_hs  = wvalid_q & axi_wready_in;

  // Ready is a decode of the state register, gated by reset so it reads 0
  // while reset is held and 1 as soon as it is released.
  assign cmd_ready_out = (state_q == MGR_IDLE) & ~axi_areset_in;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge register values, independent of statement order.
  always_ff @(posedge axi_aclk_in) begin
    if (axi_areset_in) begin
      state_q     <= MGR_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      unique case (state_q)
        MGR_IDLE: begin
          if (cmd_valid_in) begin
            if (cmd_write_in) begin
              awaddr_q  <= cmd_addr_in;
              wdata_q   <= cmd_wdata_in;
              wstrb_q   <= cmd_wstrb_in;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= MGR_WR_REQ;
            end else begin
              araddr_q  <= cmd_addr_in;
              arvalid_q <= 1'b1;
              state_q   <= MGR_RD_REQ;
            end
          end
        end

        MGR_WR_REQ: begin
          // AW and W complete independently; each valid drops the cycle
          // after its own handshake while the other may still be waiting.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // Include this cycle's handshakes so simultaneous completion
          // advances without an extra cycle.
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= MGR_WR_RESP;
          end
        end

        MGR_WR_RESP: begin
          if (axi_bvalid_in) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= axi_resp_t'(axi_bresp_in);
            state_q     <= MGR_DONE;
          end
        end

        MGR_RD_REQ: begin
          if (axi_arready_in) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= MGR_RD_RESP;
          end
        end

        MGR_RD_RESP: begin
          if (axi_rvalid_in) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= axi_rdata_in;
            rsp_resp_q  <= axi_resp_t'(axi_rresp_in);
            state_q     <= MGR_DONE;
          end
        end

        MGR_DONE: begin
          if (rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            state_q     <= MGR_IDLE;
          end
        end

        default: state_q <= MGR_IDLE;
      endcase
    end
  end

  assign axi_awaddr_out  = awaddr_q;
  assign axi_awprot_out  = PROT;
  assign axi_awvalid_out = awvalid_q;
  assign axi_wdata_out   = wdata_q;
  assign axi_wstrb_out   = wstrb_q;
  assign axi_wvalid_out  = wvalid_q;
  assign axi_bready_out  = bready_q;
  assign axi_araddr_out  = araddr_q;
  assign axi_arprot_out  = PROT;
  assign axi_arvalid_out = arvalid_q;
  assign axi_rready_out  = rready_q;

  assign rsp_valid_out = rsp_valid_q;
  assign rsp_write_out = rsp_write_q;
  assign rsp_rdata_out = rsp_rdata_q;
  assign rsp_resp_out  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_manager.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_manager
// Directed bench for axi_lite_manager. A small AXI-Lite subordinate model with
// configurable ready delays serves a 4-word register file. Expected responses
// are queued when commands are issued; a monitor pops and compares them on
// every response handshake.
// -----------------------------------------------------------------------------
module tb_axi_lite_manager;
  import axi_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .axi_aclk_in     (clk),
    .axi_areset_in   (rst),
    .cmd_valid_in    (cmd_valid),
    .cmd_ready_out   (cmd_ready),
    .cmd_write_in    (cmd_write),
    .cmd_addr_in     (cmd_addr),
    .cmd_wdata_in    (cmd_wdata),
    .cmd_wstrb_in    (cmd_wstrb),
    .rsp_valid_out   (rsp_valid),
    .rsp_ready_in    (rsp_ready),
    .rsp_write_out   (rsp_write),
    .rsp_rdata_out   (rsp_rdata),
    .rsp_resp_out    (rsp_resp),
    .axi_awaddr_out  (awaddr),
    .axi_awprot_out  (awprot),
    .axi_awvalid_out (awvalid),
    .axi_awready_in  (awready),
    .axi_wdata_out   (wdata),
    .axi_wstrb_out   (wstrb),
    .axi_wvalid_out  (wvalid),
    .axi_wready_in   (wready),
    .axi_bresp_in    (bresp),
    .axi_bvalid_in   (bvalid),
    .axi_bready_out  (bready),
    .axi_araddr_out  (araddr),
    .axi_arprot_out  (arprot),
    .axi_arvalid_out (arvalid),
    .axi_arready_in  (arready),
    .axi_rdata_in    (rdata),
    .axi_rresp_in    (rresp),
    .axi_rvalid_in   (rvalid),
    .axi_rready_out  (rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  rsp_t exp_q[$];

  // Subordinate model controls
  logic [DW-1:0] mem [4];
  int            aw_delay = 0;
  int            w_delay  = 0;
  int            ar_delay = 0;
  logic          b_suppress = 1'b0;
  logic [1:0]    rresp_force = 2'b00;
  int            b_count = 0;

  // ---------------------------------------------------------------------------
  // Subordinate model: acts 2 time units after each rising edge. Handshakes on
  // the edge just passed are derived from the values seen on the previous step.
  // ---------------------------------------------------------------------------
  initial begin : subordinate
    logic          aw_v_s, w_v_s, ar_v_s, b_r_s, r_r_s, rst_s;
    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic          aw_have, w_have;
    logic [AW-1:0] awaddr_s, araddr_s, wa;
    logic [DW-1:0] wdata_s, wd;
    logic [SW-1:0] wstrb_s, ws;
    int            aw_cnt, w_cnt, ar_cnt;

    for (int i = 0; i < 4; i++) mem[i] = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    aw_v_s = 1'b0; w_v_s = 1'b0; ar_v_s = 1'b0; b_r_s = 1'b0; r_r_s = 1'b0;
    rst_s = 1'b1; aw_have = 1'b0; w_have = 1'b0;
    awaddr_s = '0; araddr_s = '0; wdata_s = '0; wstrb_s = '0;
    wa = '0; wd = '0; ws = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;

    forever begin
      @(posedge clk);
      #2;
      if (rst_s) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0;
        aw_have = 1'b0; w_have = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        aw_hs = aw_v_s & awready;
        w_hs  = w_v_s & wready;
        ar_hs = ar_v_s & arready;
        b_hs  = bvalid & b_r_s;
        r_hs  = rvalid & r_r_s;

        // Payload stability while waiting, and valid drop after handshake
        if (aw_v_s && !aw_hs) check("aw_held", {awvalid, awaddr}, {1'b1, awaddr_s});
        if (w_v_s && !w_hs)   check("w_held", {wvalid, wstrb, wdata}, {1'b1, wstrb_s, wdata_s});
        if (ar_v_s && !ar_hs) check("ar_held", {arvalid, araddr}, {1'b1, araddr_s});
        if (aw_hs) check("awvalid_drop", awvalid, 1'b0);
        if (w_hs)  check("wvalid_drop", wvalid, 1'b0);
        if (awvalid || wvalid || arvalid) check("resp_ready_early", {bready, rready}, 2'b00);

        if (aw_hs) begin aw_have = 1'b1; wa = awaddr_s; end
        if (w_hs)  begin w_have = 1'b1; wd = wdata_s; ws = wstrb_s; end
        if (b_hs)  begin bvalid = 1'b0; b_count++; end
        if (r_hs)  rvalid = 1'b0;

        if (aw_have && w_have && !bvalid && !b_suppress) begin
          for (int b = 0; b < SW; b++)
            if (ws[b]) mem[wa[3:2]][b*8 +: 8] = wd[b*8 +: 8];
          bvalid = 1'b1; bresp = RESP_OKAY;
          aw_have = 1'b0; w_have = 1'b0;
        end
        if (ar_hs) begin
          rvalid = 1'b1; rdata = mem[araddr_s[3:2]]; rresp = rresp_force;
        end

        awready = awvalid && (aw_cnt >= aw_delay);
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_delay);
        w_cnt   = wvalid ? w_cnt + 1 : 0;
        arready = arvalid && (ar_cnt >= ar_delay);
        ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      end
      aw_v_s = awvalid; w_v_s = wvalid; ar_v_s = arvalid;
      b_r_s = bready; r_r_s = rready; rst_s = rst;
      awaddr_s = awaddr; wdata_s = wdata; wstrb_s = wstrb; araddr_s = araddr;
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor: compares every response handshake against the queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_write", rsp_write, e.write);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp", rsp_resp, e.resp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait for acceptance and check the request appears on
  // the cycle right after the accepting edge.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb,
                           input rsp_t exp);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("cmd_accept_timeout", 1'b0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(exp);
    if (wr) check("wr_req_issue", {awvalid, wvalid, awaddr, wstrb, wdata}, {1'b1, 1'b1, addr, strb, data});
    else    check("rd_req_issue", {arvalid, araddr}, {1'b1, addr});
  endtask

  // Wait for the response (counting from the accepting edge) and consume it.
  task automatic finish_rsp(input int exp_lat);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    if (lat >= 100) check("rsp_timeout", 1'b0, 1'b1);
    else if (exp_lat > 0) check("rsp_latency", lat, exp_lat);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  function automatic rsp_t mk(input logic wr, input logic [DW-1:0] d, input logic [1:0] r);
    rsp_t t;
    t.write = wr; t.rdata = d; t.resp = r;
    return t;
  endfunction

  function automatic logic [127:0] all_outputs();
    return {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
            awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
            araddr, arprot, arvalid, rready};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", all_outputs(), 128'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);

    // Write then read back with an always-ready subordinate
    issue_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, mk(1'b1, 32'h0, RESP_OKAY));
    finish_rsp(3);
    issue_cmd(1'b0, 4'h4, 32'h0, 4'h0, mk(1'b0, 32'hDEADBEEF, RESP_OKAY));
    finish_rsp(3);

    // W accepted 3 cycles after AW; partial strobes
    w_delay = 3;
    b0 = b_count;
    issue_cmd(1'b1, 4'h8, 32'h12345678, 4'b0011, mk(1'b1, 32'h0, RESP_OKAY));
    finish_rsp(0);
    check("single_b", b_count - b0, 1);
    w_delay = 0;
    issue_cmd(1'b0, 4'h8, 32'h0, 4'h0, mk(1'b0, 32'h00005678, RESP_OKAY));
    finish_rsp(3);

    // SLVERR passthrough, response held, pending command blocked
    rresp_force = RESP_SLVERR;
    issue_cmd(1'b0, 4'h4, 32'h0, 4'h0, mk(1'b0, 32'hDEADBEEF, RESP_SLVERR));
    while (!rsp_valid) tick();
    rresp_force = RESP_OKAY;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC;
    cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rsp_hold", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready, awvalid},
            {1'b1, 1'b0, 32'hDEADBEEF, RESP_SLVERR, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", {cmd_ready, awvalid}, {1'b1, 1'b0});
    issue_cmd(1'b1, 4'hC, 32'hA5A5A5A5, 4'hF, mk(1'b1, 32'h0, RESP_OKAY));
    finish_rsp(0);
    issue_cmd(1'b0, 4'hC, 32'h0, 4'h0, mk(1'b0, 32'hA5A5A5A5, RESP_OKAY));
    finish_rsp(3);

    // Reset while waiting for B
    b_suppress = 1'b1;
    issue_cmd(1'b1, 4'h0, 32'h11111111, 4'hF, mk(1'b1, 32'h0, RESP_OKAY));
    begin
      int n;
      n = 0;
      while (!bready && n < 20) begin tick(); n++; end
      check("reach_wr_resp", bready, 1'b1);
    end
    rst = 1'b1;
    tick();
    check("mid_txn_reset", all_outputs(), 128'd0);
    exp_q.delete();
    b_suppress = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("cmd_ready_after_mid_reset", cmd_ready, 1'b1);
    issue_cmd(1'b0, 4'h0, 32'h0, 4'h0, mk(1'b0, 32'h0, RESP_OKAY));
    finish_rsp(3);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
